cbus_arbiter: RTL and testbench
===============================

// Module: cbus_arbiter
// PURPOSE
//  Shares the single cache-bus (cbus) port to memory between NUM_INPUTS cache masters (ICache, DCache, ...).
//  Sits between the per-cache cbus_req_t/cbus_resp_t ports and the top-level creq/cresp.
//  Uses round-robin arbitration and holds the grant for one whole transaction (burst) until the final beat.
//  Flags downstream protocol errors (early or late last) in a sticky status bit.
// PARAMETERS
//  NUM_INPUTS  2  number of upstream cbus masters (>=2); index 0 wins the first arbitration after reset
// PORTS
//  clk        in   1                        clock
//  reset      in   1                        asynchronous, active-high reset
//  ireqs      in   cbus_req_t[NUM_INPUTS]   upstream requests
//  iresps     out  cbus_resp_t[NUM_INPUTS]  upstream responses
//  oreq       out  cbus_req_t               request to memory/bus
//  oresp      in   cbus_resp_t              response from memory/bus
//  busy       out  1                        transaction in flight (state==BUSY)
//  grant_idx  out  $clog2(NUM_INPUTS)       currently or last granted master
//  proto_err  out  1                        sticky: beat count mismatched len
// BEHAVIOUR
//  Reset (async, active-high):
//   - state=IDLE, grant_idx=0, last_grant=NUM_INPUTS-1, beat_cnt=0, proto_err=0.
//   - oreq='0; all iresps='0.
//  FSM:
//   - IDLE: if any ireqs[i].valid, pick the first valid index after last_grant (wrapping mod NUM_INPUTS).
//     Register it in grant_idx, clear beat_cnt, and go to BUSY. No valid: stay in IDLE.
//   - BUSY: oreq=ireqs[grant_idx] (combinational). iresps[grant_idx]=oresp; every other iresps='0.
//     - Each cycle with oresp.ready: beat_cnt++.
//     - On oresp.ready && oresp.last: last_grant<=grant_idx and go to IDLE.
//     - If ireqs[grant_idx].valid drops while BUSY (upstream abort/violation): go to IDLE next cycle.
//       last_grant is still updated. proto_err is unaffected.
//  Outputs in IDLE: oreq='0, all iresps='0. No response ever reaches a non-granted master.
//  Latency and throughput:
//   - 1 cycle from a request's valid rising in IDLE to oreq.valid.
//   - 1-cycle IDLE bubble minimum between back-to-back transactions.
//  Fairness: a master requesting continuously is granted at most once per NUM_INPUTS transactions
//   while others request.
//  Simultaneous events: a new valid arriving in the same cycle as last is ignored that cycle and
//   arbitrated in the following IDLE cycle.
//  Width/check rules:
//   - beat_cnt is 8 bits.
//   - On the last beat, proto_err<=1 if beat_cnt != oreq.len, compared before the increment
//     (len is beats-1, e.g. MLEN16 -> 15).
//   - Also proto_err<=1 if beat_cnt would pass oreq.len without last; saturate, do not wrap.
//  Reset mid-burst: immediately back to IDLE with outputs zeroed. No grant is remembered.
// STRUCTURE
//  common package:
//   - cbus_req_t/cbus_resp_t (existing)
//   - new arb_state_t enum {ARB_IDLE, ARB_BUSY}
//   - localparam ARB_CNT_W=8
//  Sub-module rr_picker #(N): combinational; inputs valid vector and last index; outputs pick index and
//   any_valid. Uses a doubled-vector priority search.
//  Top: state/grant/counter registers in one always_ff (async reset); output muxing in always_comb.
// TESTING
//  1. Single master: ireqs[1] MLEN1 read, valid at t0.
//     -> oreq.valid at t0+1 with addr passed through; mem ready+last at t2.
//     -> iresps[1].last=1, busy=0 at t3, proto_err=0.
//  2. Contention: both valid at t0, last_grant=1 after reset.
//     -> master 0 granted first, MLEN4 burst of 4 ready beats; master 1 granted in the next IDLE cycle.
//     -> iresps[1] stays '0 throughout master 0's burst.
//  3. Fairness: both assert valid continuously for 6 transactions.
//     -> grant sequence 0,1,0,1,0,1; no master served twice in a row.
//  4. Early last: MLEN16 read, memory asserts last on beat 5.
//     -> proto_err=1 and stays 1 through later clean transactions until reset.
//  5. Abort: granted master drops valid after beat 2 of 8.
//     -> IDLE next cycle, oreq.valid=0, other pending master granted one cycle later.
//  6. Async reset at beat 3 of a write burst (no clock edge).
//     -> oreq.valid=0 and busy=0 immediately; after release, master 0 wins first.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus request/response types plus the arbiter's state and counter definitions.
package cbus_arbiter_pkg;

    localparam int ARB_CNT_W = 8;

    // Burst length is encoded as beats-1.
    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        mlen_t       len;
        logic [31:0] data;
        logic [3:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index strictly after last_idx, wrapping.
module rr_picker #(
    parameter int N = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any_valid
);

    // Searching the doubled vector from last_idx+1 avoids an explicit rotate.
    logic [2*N-1:0]   dbl_valid;
    logic [N-1:0]     hit;
    logic [IDX_W-1:0] cand_idx [N];

    assign dbl_valid = {valid, valid};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] pos;
            assign pos           = {1'b0, last_idx} + (IDX_W+1)'(gi + 1);
            assign hit[gi]       = dbl_valid[pos];
            assign cand_idx[gi]  = (pos >= (IDX_W+1)'(N)) ? IDX_W'(pos - (IDX_W+1)'(N))
                                                          : IDX_W'(pos);
        end
    endgenerate

    always_comb begin
        pick_idx  = '0;
        any_valid = |valid;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick_idx = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cbus port between several cache masters; the grant is
// held for a whole burst and beat-count/len mismatches raise a sticky protocol error.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    localparam int IDX_W = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx,
    output logic             proto_err
);

    arb_state_t           state_q,      state_d;
    logic [IDX_W-1:0]     grant_idx_q,  grant_idx_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [ARB_CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic                 proto_err_q,  proto_err_d;

    logic [NUM_INPUTS-1:0] valid_vec;
    logic [IDX_W-1:0]      pick_idx;
    logic                  any_valid;
    cbus_req_t             cur_req;
    logic [ARB_CNT_W-1:0]  cur_len;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
            assign valid_vec[gi] = ireqs[gi].valid;
        end
    endgenerate

    rr_picker #(
        .N (NUM_INPUTS)
    ) u_picker (
        .valid     (valid_vec),
        .last_idx  (last_grant_q),
        .pick_idx  (pick_idx),
        .any_valid (any_valid)
    );

    assign cur_req = ireqs[grant_idx_q];
    assign cur_len = ARB_CNT_W'(cur_req.len);

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        proto_err_d  = proto_err_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    grant_idx_d = pick_idx;
                    beat_cnt_d  = '0;
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A master that drops valid mid-burst abandons the bus; its beats are not audited.
                if (!cur_req.valid) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_idx_q;
                end else if (oresp.ready) begin
                    beat_cnt_d = sat_inc(beat_cnt_q);
                    if (oresp.last) begin
                        if (beat_cnt_q != cur_len) begin
                            proto_err_d = 1'b1;
                        end
                        state_d      = ARB_IDLE;
                        last_grant_d = grant_idx_q;
                    end else if (beat_cnt_q >= cur_len) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_INPUTS - 1);
            beat_cnt_q   <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign busy      = (state_q == ARB_BUSY);
    assign grant_idx = grant_idx_q;
    assign proto_err = proto_err_q;
    assign oreq      = busy ? cur_req : '0;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_resp
            assign iresps[gi] = (busy && grant_idx_q == IDX_W'(gi)) ? oresp : '0;
        end
    endgenerate

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: a transaction table, directed corner cases and a
// randomized run against a transaction-level round-robin model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    cbus_req_t            ireqs  [N];
    cbus_resp_t           iresps [N];
    cbus_req_t            oreq;
    cbus_resp_t           oresp;
    logic                 busy;
    logic [$clog2(N)-1:0] grant_idx;
    logic                 proto_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] mask;
        logic [3:0] len;
        int         last_beat;
        int         exp_grant;
        logic       exp_err;
    } vec_t;

    vec_t       tab [11];
    logic [3:0] len_tab [5];

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk       (clk),
        .reset     (rst),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] len,
                           input logic [31:0] addr, input logic wr);
        ireqs[i].valid    = v;
        ireqs[i].is_write = wr;
        ireqs[i].addr     = addr;
        ireqs[i].len      = len;
        ireqs[i].data     = $urandom;
        ireqs[i].strobe   = 4'hF;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_oreq"}, 128'(oreq), 128'(0));
        for (int i = 0; i < N; i++) check({name, "_iresp"}, 128'(iresps[i]), 128'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant", 128'(grant_idx), 128'(0));
        check("rst_proto_err", 128'(proto_err), 128'(0));
        check_quiet("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One arbitration plus a burst of back-to-back ready beats, last on beat last_beat.
    task automatic run_txn(input logic [1:0] mask, input logic [3:0] len, input int last_beat,
                           input int exp_g, input logic exp_err, input int tag);
        cbus_req_t exp_req;
        tick();
        for (int i = 0; i < N; i++)
            set_req(i, ((int'(mask) >> i) & 1) != 0, len, 32'h1000_0000 + 32'(i * 256 + tag), 1'(tag));
        oresp.ready = 1'($urandom_range(0, 1));
        oresp.last  = 1'($urandom_range(0, 1));
        oresp.data  = $urandom;
        @(negedge clk);
        check("txn_idle_busy", 128'(busy), 128'(0));
        check_quiet("txn_idle");
        exp_req = ireqs[exp_g];
        for (int b = 0; b <= last_beat; b++) begin
            tick();
            oresp.ready = 1'b1;
            oresp.last  = (b == last_beat);
            oresp.data  = $urandom;
            @(negedge clk);
            if (b == 0) begin
                check("txn_busy", 128'(busy), 128'(1));
                check("txn_grant", 128'(grant_idx), 128'(exp_g));
            end
            check("txn_oreq", 128'(oreq), 128'(exp_req));
            check("txn_iresp_owner", 128'(iresps[exp_g]), 128'(oresp));
            check("txn_iresp_other", 128'(iresps[1 - exp_g]), 128'(0));
        end
        tick();
        clear_inputs();
        @(negedge clk);
        check("txn_end_busy", 128'(busy), 128'(0));
        check("txn_end_grant", 128'(grant_idx), 128'(exp_g));
        check("txn_end_proto_err", 128'(proto_err), 128'(exp_err));
        check("txn_end_oreq", 128'(oreq), 128'(0));
    endtask

    task automatic run_random(input int cycles);
        bit   pending [N];
        bit   m_busy;
        int   m_grant, m_last, m_beat;
        bit   m_err;
        bit   found;
        int   j;
        cbus_req_t  exp_oreq;
        cbus_resp_t exp_resp;
        do_reset();
        for (int i = 0; i < N; i++) pending[i] = 1'b0;
        m_busy = 0; m_grant = 0; m_last = N - 1; m_beat = 0; m_err = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) begin
                    pending[i]        = 1'b1;
                    ireqs[i].is_write = 1'($urandom_range(0, 1));
                    ireqs[i].addr     = $urandom;
                    ireqs[i].len      = len_tab[$urandom_range(0, 4)];
                    ireqs[i].strobe   = 4'($urandom_range(0, 15));
                end else if (!pending[i]) begin
                    ireqs[i].addr = $urandom;
                    ireqs[i].len  = 4'($urandom_range(0, 15));
                end
                ireqs[i].valid = pending[i];
                ireqs[i].data  = $urandom;
            end
            if (m_busy) begin
                oresp.ready = ($urandom_range(0, 3) != 0);
                oresp.last  = oresp.ready && (m_beat == int'(ireqs[m_grant].len));
            end else begin
                oresp.ready = 1'($urandom_range(0, 1));
                oresp.last  = 1'($urandom_range(0, 1));
            end
            oresp.data = $urandom;
            @(negedge clk);
            exp_oreq = m_busy ? ireqs[m_grant] : '0;
            check("rnd_busy", 128'(busy), 128'(m_busy));
            check("rnd_grant", 128'(grant_idx), 128'(m_grant));
            check("rnd_proto_err", 128'(proto_err), 128'(m_err));
            check("rnd_oreq", 128'(oreq), 128'(exp_oreq));
            for (int i = 0; i < N; i++) begin
                exp_resp = (m_busy && i == m_grant) ? oresp : '0;
                check("rnd_iresp", 128'(iresps[i]), 128'(exp_resp));
            end
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (!found && pending[j]) begin
                        found = 1'b1; m_busy = 1'b1; m_grant = j; m_beat = 0;
                    end
                end
            end else if (oresp.ready) begin
                if (oresp.last) begin
                    if (m_beat != int'(ireqs[m_grant].len)) m_err = 1'b1;
                    m_busy = 1'b0;
                    m_last = m_grant;
                    pending[m_grant] = 1'b0;
                end else begin
                    if (m_beat >= int'(ireqs[m_grant].len)) m_err = 1'b1;
                    m_beat++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        len_tab = '{MLEN1, MLEN4, MLEN8, MLEN16, 4'd1};

        // Grant order after reset starts at master 0; rows 2..7 are the fairness run.
        tab[0]  = '{mask: 2'b01, len: MLEN1,  last_beat: 0,  exp_grant: 0, exp_err: 1'b0};
        tab[1]  = '{mask: 2'b10, len: MLEN4,  last_beat: 3,  exp_grant: 1, exp_err: 1'b0};
        tab[2]  = '{mask: 2'b11, len: MLEN1,  last_beat: 0,  exp_grant: 0, exp_err: 1'b0};
        tab[3]  = '{mask: 2'b11, len: 4'd1,   last_beat: 1,  exp_grant: 1, exp_err: 1'b0};
        tab[4]  = '{mask: 2'b11, len: MLEN4,  last_beat: 3,  exp_grant: 0, exp_err: 1'b0};
        tab[5]  = '{mask: 2'b11, len: MLEN1,  last_beat: 0,  exp_grant: 1, exp_err: 1'b0};
        tab[6]  = '{mask: 2'b11, len: MLEN8,  last_beat: 7,  exp_grant: 0, exp_err: 1'b0};
        tab[7]  = '{mask: 2'b11, len: MLEN16, last_beat: 15, exp_grant: 1, exp_err: 1'b0};
        tab[8]  = '{mask: 2'b10, len: MLEN16, last_beat: 4,  exp_grant: 1, exp_err: 1'b1};
        tab[9]  = '{mask: 2'b01, len: MLEN1,  last_beat: 0,  exp_grant: 0, exp_err: 1'b1};
        tab[10] = '{mask: 2'b11, len: MLEN4,  last_beat: 3,  exp_grant: 1, exp_err: 1'b1};

        do_reset();
        for (int r = 0; r < 11; r++)
            run_txn(tab[r].mask, tab[r].len, tab[r].last_beat, tab[r].exp_grant, tab[r].exp_err, r);

        // Late last: MLEN4 burst whose last arrives on beat index 5.
        do_reset();
        run_txn(2'b01, MLEN4, 5, 0, 1'b1, 40);

        // Abort: master 0 drops valid after two of eight beats while master 1 waits.
        do_reset();
        tick();
        set_req(0, 1'b1, MLEN8, 32'hA000_0000, 1'b0);
        set_req(1, 1'b1, MLEN8, 32'hB000_0000, 1'b0);
        @(negedge clk);
        check("abort_idle_busy", 128'(busy), 128'(0));
        tick();
        oresp.ready = 1'b1;
        oresp.last  = 1'b0;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'(1));
        check("abort_grant0", 128'(grant_idx), 128'(0));
        tick();
        @(negedge clk);
        check("abort_beat2_resp", 128'(iresps[0]), 128'(oresp));
        tick();
        oresp.ready     = 1'b0;
        ireqs[0].valid  = 1'b0;
        @(negedge clk);
        check("abort_drop_busy", 128'(busy), 128'(1));
        check("abort_drop_oreq_valid", 128'(oreq.valid), 128'(0));
        tick();
        @(negedge clk);
        check("abort_idle2_busy", 128'(busy), 128'(0));
        check("abort_idle2_oreq", 128'(oreq), 128'(0));
        tick();
        @(negedge clk);
        check("abort_next_busy", 128'(busy), 128'(1));
        check("abort_next_grant", 128'(grant_idx), 128'(1));
        check("abort_next_addr", 128'(oreq.addr), 128'(32'hB000_0000));
        check("abort_proto_err", 128'(proto_err), 128'(0));

        // Asynchronous reset in the middle of beat 3 of a write burst.
        do_reset();
        tick();
        set_req(1, 1'b1, MLEN8, 32'hC000_0000, 1'b1);
        @(negedge clk);
        check("areset_idle_busy", 128'(busy), 128'(0));
        for (int b = 0; b < 3; b++) begin
            tick();
            oresp.ready = 1'b1;
            oresp.last  = 1'b0;
            @(negedge clk);
            check("areset_beat_grant", 128'(grant_idx), 128'(1));
        end
        #2;
        rst = 1'b1;
        #1;
        check("areset_busy", 128'(busy), 128'(0));
        check("areset_oreq_valid", 128'(oreq.valid), 128'(0));
        check("areset_grant", 128'(grant_idx), 128'(0));
        check("areset_iresp1", 128'(iresps[1]), 128'(0));
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        run_txn(2'b11, MLEN1, 0, 0, 1'b0, 60);

        run_random(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
